// File: rtl/phi_integrator_pkg.sv
// Shared constants for the phi-n integrator: FSM encodings and default tuning values.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package phi_integrator_pkg;

  // FSM encodings (kept as plain vectors for compatibility with older tooling)
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SWEEP = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  // Default numeric tuning, all in signed Q4.14
  localparam int DEF_MAX_STEP    = 819;     // 0.05 per sweep
  localparam int DEF_N_MIN       = -65536;  // -4.0
  localparam int DEF_N_MAX       = 114688;  // +7.0
  localparam int N_RESET         = 8192;    // 0.5
  localparam int DEF_DWELL_LIMIT = 8;

  // Dwell counters are 4 bits and stick at their maximum
  localparam int         DWELL_W   = 4;
  localparam logic [3:0] DWELL_MAX = 4'd15;

endpackage

// File: rtl/phi_step_sat.sv
// Per-oscillator step: force >>> GAIN_SHIFT, clamp step, add to n, saturate n to [N_MIN, N_MAX].
// Latency: purely combinational, zero cycles.
// Backpressure: none; the caller time-multiplexes one oscillator per cycle.
//
// Ports:
//   n_cur     : current n (signed Q4.14)
//   force_val : landscape force for this oscillator (signed Q4.14)
//   n_next    : updated, saturated n
//   sat       : high when the sum fell outside [N_MIN, N_MAX] and was clipped
module phi_step_sat #(
  parameter int WIDTH      = 18,
  parameter int GAIN_SHIFT = 4,
  parameter int MAX_STEP   = 819,
  parameter int N_MIN      = -65536,
  parameter int N_MAX      = 114688
) (
  input  logic signed [WIDTH-1:0] n_cur,
  input  logic signed [WIDTH-1:0] force_val,
  output logic signed [WIDTH-1:0] n_next,
  output logic                    sat
);

  localparam int WP1 = WIDTH + 1;

  localparam logic signed [WIDTH-1:0] STEP_POS = WIDTH'(MAX_STEP);
  localparam logic signed [WIDTH-1:0] STEP_NEG = WIDTH'(-MAX_STEP);
  localparam logic signed [WIDTH:0]   LIM_HI   = WP1'(N_MAX);
  localparam logic signed [WIDTH:0]   LIM_LO   = WP1'(N_MIN);

  logic signed [WIDTH-1:0] step_raw;
  logic signed [WIDTH-1:0] step;
  logic signed [WIDTH:0]   sum;

  always_comb begin
    // Arithmetic shift rounds toward -inf, so small negative forces still nudge n down
    step_raw = force_val >>> GAIN_SHIFT;

    step = step_raw;
    if (step_raw > STEP_POS) begin
      step = STEP_POS;
    end else if (step_raw < STEP_NEG) begin
      step = STEP_NEG;
    end

    // One guard bit so the add itself can never wrap before the bound check
    sum = {n_cur[WIDTH-1], n_cur} + {step[WIDTH-1], step};

    n_next = sum[WIDTH-1:0];
    sat    = 1'b0;
    if (sum > LIM_HI) begin
      n_next = LIM_HI[WIDTH-1:0];
      sat    = 1'b1;
    end else if (sum < LIM_LO) begin
      n_next = LIM_LO[WIDTH-1:0];
      sat    = 1'b1;
    end
  end

endmodule

// File: rtl/phi_n_integrator.sv
// Sweeps all oscillators once per request, integrating clamped landscape force into n with bounds and dwell-escape tracking.
// Latency: request to done pulse is NUM_OSCILLATORS+1 enabled cycles; one oscillator per enabled cycle.
// Backpressure: none; requests arriving while busy are dropped and latch the sticky overrun flag.
//
// Ports:
//   clk, rst           : clock, asynchronous active-high reset
//   clk_en             : global advance enable, all state frozen while low
//   update_req         : one-cycle sweep request (accepted in IDLE only)
//   load_init          : load n_init_packed, clear dwell/flags/overrun, return to IDLE
//   n_init_packed      : initial n values, oscillator i at [i*WIDTH +: WIDTH]
//   force_packed       : signed landscape forces, snapshotted at request time
//   near_harmonic_2_1  : catastrophe-zone flags, snapshotted at request time
//   n_packed           : current n per oscillator
//   busy / done        : sweep in progress / one-cycle completion pulse
//   overrun            : sticky, a request arrived while a sweep was outstanding
//   sat_flag           : per-oscillator bound hit on its last update
//   escape_flag        : per-oscillator dwell count reached DWELL_LIMIT
module phi_n_integrator
  import phi_integrator_pkg::*;
#(
  parameter int WIDTH           = 18,
  parameter int FRAC            = 14,
  parameter int NUM_OSCILLATORS = 21,
  parameter int GAIN_SHIFT      = 4,
  parameter int MAX_STEP        = DEF_MAX_STEP,
  parameter int N_MIN           = DEF_N_MIN,
  parameter int N_MAX           = DEF_N_MAX,
  parameter int DWELL_LIMIT     = DEF_DWELL_LIMIT
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             clk_en,
  input  logic                             update_req,
  input  logic                             load_init,
  input  logic [NUM_OSCILLATORS*WIDTH-1:0] n_init_packed,
  input  logic [NUM_OSCILLATORS*WIDTH-1:0] force_packed,
  input  logic [NUM_OSCILLATORS-1:0]       near_harmonic_2_1,
  output logic [NUM_OSCILLATORS*WIDTH-1:0] n_packed,
  output logic                             busy,
  output logic                             done,
  output logic                             overrun,
  output logic [NUM_OSCILLATORS-1:0]       sat_flag,
  output logic [NUM_OSCILLATORS-1:0]       escape_flag
);

  localparam int IDX_W = (NUM_OSCILLATORS > 1) ? $clog2(NUM_OSCILLATORS) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_OSCILLATORS - 1);

  // Reset point is 0.5; derive it from FRAC if the fixed-point format changes
  localparam int                N_RST_VAL = (FRAC == 14) ? N_RESET : (1 << (FRAC - 1));
  localparam logic [WIDTH-1:0]  N_RST_W   = WIDTH'(N_RST_VAL);
  localparam logic [DWELL_W:0]  DWELL_LIM = (DWELL_W + 1)'(DWELL_LIMIT);

  logic [1:0]                       state_q;
  logic [IDX_W-1:0]                 idx_q;
  logic [NUM_OSCILLATORS*WIDTH-1:0] n_q;
  logic [NUM_OSCILLATORS*WIDTH-1:0] force_snap_q;
  logic [NUM_OSCILLATORS-1:0]       flag_snap_q;
  logic [DWELL_W-1:0]               dwell_q [NUM_OSCILLATORS];
  logic [NUM_OSCILLATORS-1:0]       sat_q;
  logic [NUM_OSCILLATORS-1:0]       esc_q;
  logic                             done_q;
  logic                             overrun_q;

  // Datapath for the oscillator currently selected by idx_q
  logic signed [WIDTH-1:0] cur_n;
  logic signed [WIDTH-1:0] cur_force;
  logic signed [WIDTH-1:0] step_n;
  logic                    step_sat;
  logic [DWELL_W-1:0]      dwell_nxt;
  logic                    esc_nxt;

  always_comb begin
    cur_n     = n_q[idx_q*WIDTH +: WIDTH];
    cur_force = force_snap_q[idx_q*WIDTH +: WIDTH];

    if (!flag_snap_q[idx_q]) begin
      dwell_nxt = '0;
    end else if (dwell_q[idx_q] == DWELL_MAX) begin
      dwell_nxt = DWELL_MAX;
    end else begin
      dwell_nxt = dwell_q[idx_q] + 1'b1;
    end
    esc_nxt = ({1'b0, dwell_nxt} >= DWELL_LIM);
  end

  phi_step_sat #(
    .WIDTH      (WIDTH),
    .GAIN_SHIFT (GAIN_SHIFT),
    .MAX_STEP   (MAX_STEP),
    .N_MIN      (N_MIN),
    .N_MAX      (N_MAX)
  ) u_step (
    .n_cur     (cur_n),
    .force_val (cur_force),
    .n_next    (step_n),
    .sat       (step_sat)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      idx_q        <= '0;
      n_q          <= {NUM_OSCILLATORS{N_RST_W}};
      force_snap_q <= '0;
      flag_snap_q  <= '0;
      sat_q        <= '0;
      esc_q        <= '0;
      done_q       <= 1'b0;
      overrun_q    <= 1'b0;
      for (int i = 0; i < NUM_OSCILLATORS; i++) begin
        dwell_q[i] <= '0;
      end
    end else if (clk_en) begin
      done_q <= 1'b0;
      if (load_init) begin
        // Load takes priority over any coincident request, which is simply dropped
        state_q   <= ST_IDLE;
        idx_q     <= '0;
        n_q       <= n_init_packed;
        sat_q     <= '0;
        esc_q     <= '0;
        overrun_q <= 1'b0;
        for (int i = 0; i < NUM_OSCILLATORS; i++) begin
          dwell_q[i] <= '0;
        end
      end else begin
        case (state_q)
          ST_IDLE: begin
            if (update_req) begin
              force_snap_q <= force_packed;
              flag_snap_q  <= near_harmonic_2_1;
              idx_q        <= '0;
              state_q      <= ST_SWEEP;
            end
          end
          ST_SWEEP: begin
            if (update_req) begin
              overrun_q <= 1'b1;
            end
            n_q[idx_q*WIDTH +: WIDTH] <= step_n;
            sat_q[idx_q]              <= step_sat;
            esc_q[idx_q]              <= esc_nxt;
            dwell_q[idx_q]            <= dwell_nxt;
            if (idx_q == IDX_LAST) begin
              state_q <= ST_DONE;
            end else begin
              idx_q <= idx_q + 1'b1;
            end
          end
          ST_DONE: begin
            if (update_req) begin
              overrun_q <= 1'b1;
            end
            done_q  <= 1'b1;
            idx_q   <= '0;
            state_q <= ST_IDLE;
          end
          default: begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
          end
        endcase
      end
    end
  end

  assign n_packed    = n_q;
  assign busy        = (state_q == ST_SWEEP);
  assign done        = done_q;
  assign overrun     = overrun_q;
  assign sat_flag    = sat_q;
  assign escape_flag = esc_q;

endmodule
